// File: rtl/calc_pkg.sv
// calc_pkg
// Shared definitions for the calculator keypad front end:
//   - memoryFlag function-key codes
//   - keypad scanner FSM state encoding
//   - key-map and row/column decode helpers used by the scanner
package calc_pkg;

  // Function-key codes carried on memoryFlag (bit 4 is the valid flag)
  localparam logic [4:0] MF_BACKSPACE  = 5'b10000;
  localparam logic [4:0] MF_MEM_STORE  = 5'b10001;
  localparam logic [4:0] MF_MEM_RECALL = 5'b10010;
  localparam logic [4:0] MF_CLEAR      = 5'b10011;
  localparam logic [4:0] MF_NEGATE     = 5'b10100;
  localparam logic [4:0] MF_EQUALS     = 5'b10101;

  typedef enum logic [2:0] {
    SCAN,
    DEB_PRESS,
    EMIT,
    HOLD,
    DEB_REL
  } scan_state_t;

  // Maps a {row, col} position to its 5-bit output code. Digit codes and
  // function codes share the same bit patterns (e.g. digit 1 and memory
  // store are both 10001), so key_is_digit decides which output port the
  // code is routed to.
  function automatic logic [4:0] key_code(input logic [1:0] row,
                                          input logic [1:0] col);
    logic [4:0] code;
    code = 5'b00000;
    case ({row, col})
      4'h0: code = {1'b1, 4'd1};
      4'h1: code = {1'b1, 4'd2};
      4'h2: code = {1'b1, 4'd3};
      4'h3: code = MF_BACKSPACE;
      4'h4: code = {1'b1, 4'd4};
      4'h5: code = {1'b1, 4'd5};
      4'h6: code = {1'b1, 4'd6};
      4'h7: code = MF_MEM_STORE;
      4'h8: code = {1'b1, 4'd7};
      4'h9: code = {1'b1, 4'd8};
      4'hA: code = {1'b1, 4'd9};
      4'hB: code = MF_MEM_RECALL;
      4'hC: code = MF_NEGATE;
      4'hD: code = {1'b1, 4'd0};
      4'hE: code = MF_EQUALS;
      4'hF: code = MF_CLEAR;
      default: code = 5'b00000;
    endcase
    return code;
  endfunction

  // Digits occupy columns 0..2, except '*' and '#' on the bottom row.
  function automatic logic key_is_digit(input logic [1:0] row,
                                        input logic [1:0] col);
    return (col != 2'd3) && !((row == 2'd3) && (col != 2'd1));
  endfunction

  // True when exactly one bit of an active-low vector is asserted.
  function automatic logic exactly_one_low(input logic [3:0] v);
    return $countones(~v) == 1;
  endfunction

  // Index of the lowest asserted bit of an active-low vector.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!v[i]) begin
        idx = 2'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync2.sv
// sync2
// Two-flop synchroniser for the 4 keypad row lines. Flops reset to all
// ones so an idle (released) keypad is seen while reset is active.
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous, active-low reset
//   d      in   [3:0] asynchronous input
//   q      out  [3:0] synchronised output
module sync2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 4'b1111;
      q    <= 4'b1111;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 active-low matrix keypad, debounces press and release, and
// emits one single-cycle code per key press. Digit keys appear on
// numberPulse as {1, digit}; function keys appear on memoryFlag.
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-low reset
//   row_n        in   [3:0] keypad rows, active-low, asynchronous to clk
//   col_n        out  [3:0] one-hot active-low column drive
//   numberPulse  out  [4:0] {1, digit} for one cycle on a digit press
//   memoryFlag   out  [4:0] function-key code for one cycle
//   key_down     out  high from press acceptance until release debounce ends
// SCAN_DIV must be at least 4 so the synchroniser has settled on the newly
// driven column before the rows are sampled; DEBOUNCE_CNT must be at least 2.
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [4:0] numberPulse,
  output logic [4:0] memoryFlag,
  output logic       key_down
);

  localparam int DWELL_W = $clog2(SCAN_DIV);
  localparam int DEB_W   = $clog2(DEBOUNCE_CNT);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CNT - 1);

  scan_state_t      state, state_next;
  logic [3:0]       rows_sync;
  logic [3:0]       col_next;
  logic [DWELL_W-1:0] dwell, dwell_next;
  logic [DEB_W-1:0] deb, deb_next;
  logic [1:0]       key_row, key_row_next;
  logic [1:0]       key_col, key_col_next;
  logic [4:0]       number_next;
  logic [4:0]       flag_next;
  logic             key_down_next;

  logic [3:0]       col_rot;
  logic [3:0]       latched_pattern;
  logic             latched_row_high;
  logic [4:0]       code;
  logic             code_is_digit;

  sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row_n),
    .q     (rows_sync)
  );

  // State and output registers. The pulse outputs are registered so the
  // code is present exactly during the EMIT cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= SCAN;
      col_n       <= 4'b1110;
      dwell       <= '0;
      deb         <= '0;
      key_row     <= 2'd0;
      key_col     <= 2'd0;
      numberPulse <= 5'b00000;
      memoryFlag  <= 5'b00000;
      key_down    <= 1'b0;
    end else begin
      state       <= state_next;
      col_n       <= col_next;
      dwell       <= dwell_next;
      deb         <= deb_next;
      key_row     <= key_row_next;
      key_col     <= key_col_next;
      numberPulse <= number_next;
      memoryFlag  <= flag_next;
      key_down    <= key_down_next;
    end
  end

  // Next-state logic. The debounce counter exits on its last value rather
  // than one past it, so a press needs DEBOUNCE_CNT consecutive matching
  // cycles in DEB_PRESS and the counter never needs to hold DEBOUNCE_CNT.
  always_comb begin
    state_next    = state;
    col_next      = col_n;
    dwell_next    = dwell;
    deb_next      = deb;
    key_row_next  = key_row;
    key_col_next  = key_col;
    number_next   = 5'b00000;
    flag_next     = 5'b00000;
    key_down_next = key_down;

    col_rot          = {col_n[2:0], col_n[3]};
    latched_pattern  = ~(4'b0001 << key_row);
    latched_row_high = rows_sync[key_row];
    code             = key_code(key_row, key_col);
    code_is_digit    = key_is_digit(key_row, key_col);

    case (state)
      SCAN: begin
        if (dwell == DWELL_LAST) begin
          dwell_next = '0;
          if (exactly_one_low(rows_sync)) begin
            key_row_next = low_index(rows_sync);
            key_col_next = low_index(col_n);
            deb_next     = '0;
            state_next   = DEB_PRESS;
          end else begin
            col_next = col_rot;
          end
        end else begin
          dwell_next = dwell + 1'b1;
        end
      end

      DEB_PRESS: begin
        if (rows_sync == latched_pattern) begin
          if (deb == DEB_LAST) begin
            state_next    = EMIT;
            key_down_next = 1'b1;
            if (code_is_digit) begin
              number_next = code;
            end else begin
              flag_next = code;
            end
          end else begin
            deb_next = deb + 1'b1;
          end
        end else begin
          state_next = SCAN;
          col_next   = col_rot;
          dwell_next = '0;
        end
      end

      EMIT: begin
        state_next = HOLD;
      end

      // Only the latched row is watched while the column is frozen, so a
      // second key on another row or column cannot disturb the release.
      HOLD: begin
        if (latched_row_high) begin
          deb_next   = '0;
          state_next = DEB_REL;
        end
      end

      DEB_REL: begin
        if (latched_row_high) begin
          if (deb == DEB_LAST) begin
            state_next    = SCAN;
            key_down_next = 1'b0;
            col_next      = col_rot;
            dwell_next    = '0;
          end else begin
            deb_next = deb + 1'b1;
          end
        end else begin
          deb_next = '0;
        end
      end

      default: begin
        state_next = SCAN;
      end
    endcase
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=8.
// A behavioural keypad pulls a row low whenever a pressed key's column is
// driven. Expected codes are queued as keys are pressed; a monitor pops
// and compares whenever the DUT presents a pulse.
module tb_keypad_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [4:0] numberPulse;
  logic [4:0] memoryFlag;
  logic       key_down;

  // Pressed keys, bit index = row*4 + col
  logic [15:0] keys = 16'h0000;

  // Expected {numberPulse, memoryFlag} per press
  logic [9:0]  sb[$];
  logic [9:0]  monExp;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  // Keypad matrix: row r reads low while any pressed key in that row has
  // its column driven low.
  always_comb begin
    row_n = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      row_n[r] = ~|(keys[r*4 +: 4] & ~col_n);
    end
  end

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .row_n       (row_n),
    .col_n       (col_n),
    .numberPulse (numberPulse),
    .memoryFlag  (memoryFlag),
    .key_down    (key_down)
  );

  // Monitor: every nonzero output cycle must match the next queued press.
  always @(negedge clk) begin
    if (reset && (numberPulse != 5'b0 || memoryFlag != 5'b0)) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpectedPulse: got num=%b mf=%b want none",
                 numberPulse, memoryFlag);
      end else begin
        monExp = sb.pop_front();
        if ({numberPulse, memoryFlag} !== monExp) begin
          bad++;
          $display("[TB] FAIL pulseCode: got num=%b mf=%b want num=%b mf=%b",
                   numberPulse, memoryFlag, monExp[9:5], monExp[4:0]);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] mask, input int cycles);
    keys = mask;
    repeat (cycles) @(negedge clk);
  endtask

  // Waits for the monitor to drain the queue within a cycle budget.
  task automatic waitPulse(input string name, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: got no pulse in %0d cycles want %0d queued code(s)",
               name, budget, sb.size());
      sb.delete();
    end
  endtask

  // Counts negedges with key_down still high after a release is applied.
  task automatic measureKeyUp(input string name, input int expHigh);
    int n;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!key_down) break;
      n++;
    end
    checkOutput(name, n, expHigh);
  endtask

  // Every column must be driven at some point within 24 cycles.
  task automatic checkRotating(input string name);
    logic [3:0] seen;
    seen = 4'b0000;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        if (!col_n[c]) seen[c] = 1'b1;
      end
    end
    checkOutput(name, seen, 4'hF);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] colExp;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("resetCol", col_n, 4'b1110);
    checkOutput("resetNum", numberPulse, 5'b0);
    checkOutput("resetFlag", memoryFlag, 5'b0);
    checkOutput("resetKeyDown", key_down, 1'b0);

    // Rotation: 4 cycles per column, wrapping back to column 0
    reset = 1'b1;
    checkOutput("rotate", col_n, 4'b1110);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      colExp = ~(4'b0001 << ((k / 4) % 4));
      checkOutput("rotate", col_n, colExp);
    end

    // Clean press of key 5 (row 1, col 1); release seen from HOLD takes
    // 2 sync + 1 detect + 8 debounce cycles, so 10 samples stay high.
    sb.push_back({5'b10101, 5'b00000});
    applyStimulus(16'h0020, 40);
    checkOutput("key5Down", key_down, 1'b1);
    waitPulse("key5Pulse", 10);
    keys = 16'h0000;
    measureKeyUp("key5Release", 10);

    // Bouncing key C: never stable for 8 cycles, so no pulse
    for (int i = 0; i < 10; i++) begin
      applyStimulus((i % 2 == 0) ? 16'h0800 : 16'h0000, 3);
    end
    keys = 16'h0000;
    checkRotating("bounceRotate");
    checkOutput("bounceKeyDown", key_down, 1'b0);

    // Stable key C: memory recall
    sb.push_back({5'b00000, 5'b10010});
    applyStimulus(16'h0800, 40);
    waitPulse("keyCPulse", 10);
    keys = 16'h0000;
    measureKeyUp("keyCRelease", 10);

    // Keys 1 and 4 together in column 0: ignored, scanning continues
    applyStimulus(16'h0011, 40);
    checkOutput("doubleKeyDown", key_down, 1'b0);
    checkRotating("doubleRotate");
    keys = 16'h0000;

    // Key D with a bouncing release; last bounce leaves DEB_REL already
    // entered, so only 2 sync + 7 further cycles remain: 9 high samples.
    sb.push_back({5'b00000, 5'b10011});
    keys = 16'h8000;
    waitPulse("keyDPulse", 60);
    checkOutput("keyDDown", key_down, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(16'h0000, 3);
      applyStimulus(16'h8000, 3);
    end
    keys = 16'h0000;
    measureKeyUp("keyDReleaseBounce", 9);

    // Reset mid-DEB_PRESS on key 0 (row 3, col 1)
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    keys = 16'h2000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (col_n == 4'b1101) break;
    end
    checkOutput("key0Col1", col_n, 4'b1101);
    repeat (8) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("midResetCol", col_n, 4'b1110);
    checkOutput("midResetNum", numberPulse, 5'b0);
    checkOutput("midResetKeyDown", key_down, 1'b0);
    keys = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    checkOutput("afterResetCol", col_n, 4'b1110);
    repeat (20) @(negedge clk);
    checkOutput("afterResetKeyDown", key_down, 1'b0);

    // Fresh press of key 0
    sb.push_back({5'b10000, 5'b00000});
    applyStimulus(16'h2000, 40);
    waitPulse("key0Pulse", 10);
    keys = 16'h0000;
    measureKeyUp("key0Release", 10);

    repeat (5) @(negedge clk);
    checkOutput("scoreboardEmpty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
